// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM channel mux/demux path.
// Slot numbering here is the same one the transmit-side channel mux uses.
package tdm_pkg;
  localparam int SLOTS = 4;

  typedef logic [1:0] slot_idx_t;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_e;
endpackage

// File: rtl/tdm_slot_counter.sv
// Mod-4 slot counter for the demux.
// load0 takes priority over en: after a slot-0 accept, the next expected slot is always 1.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load0,
  output logic [1:0] cnt
);

  slot_idx_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load0) begin
      cnt_d = slot_idx_t'(1);
    end else if (en) begin
      if (cnt_q == slot_idx_t'(SLOTS - 1)) cnt_d = '0;
      else                                 cnt_d = cnt_q + slot_idx_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tdm_demux_4ch.sv
// Receive-side 4-channel TDM demultiplexer: locks on sync, gathers slots 0..2 in shadow
// registers and publishes a whole frame on the slot-3 accept.
//
// state  | meaning
// HUNT   | no alignment; discard samples until one arrives with sync
// LOCKED | aligned; cnt is the slot expected for the next valid sample
module tdm_demux_4ch
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             s0,
  output logic             s1,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  tdm_state_e       state_q, state_d;
  slot_idx_t        slot_q, slot_d;
  slot_idx_t        cnt;
  logic             fv_q, fv_d;
  logic             err_q, err_d;
  logic             cnt_en, cnt_load0;
  logic [2:0]       sh_we;
  logic             out_we;
  logic [WIDTH-1:0] sh0_q, sh1_q, sh2_q;
  logic [WIDTH-1:0] a_q, b_q, c_q, d_q;

  tdm_slot_counter u_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .load0 (cnt_load0),
    .cnt   (cnt)
  );

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    fv_d      = 1'b0;
    err_d     = 1'b0;
    cnt_en    = 1'b0;
    cnt_load0 = 1'b0;
    sh_we     = 3'b000;
    out_we    = 1'b0;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            state_d   = LOCKED;
            cnt_load0 = 1'b1;
            sh_we[0]  = 1'b1;
            slot_d    = '0;
          end
        end
        LOCKED: begin
          if (sync && cnt != 2'd0) begin
            // Early sync: restart the frame on this sample rather than dropping lock.
            err_d     = 1'b1;
            cnt_load0 = 1'b1;
            sh_we[0]  = 1'b1;
            slot_d    = '0;
          end else if (!sync && cnt == 2'd0) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else begin
            cnt_en = 1'b1;
            slot_d = cnt;
            case (cnt)
              2'd0:    sh_we[0] = 1'b1;
              2'd1:    sh_we[1] = 1'b1;
              2'd2:    sh_we[2] = 1'b1;
              default: begin
                out_we = 1'b1;
                fv_d   = 1'b1;
              end
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
      if (sh_we[0]) sh0_q <= din;
      if (sh_we[1]) sh1_q <= din;
      if (sh_we[2]) sh2_q <= din;
      if (out_we) begin
        a_q <= sh0_q;
        b_q <= sh1_q;
        c_q <= sh2_q;
        d_q <= din;
      end
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign c           = c_q;
  assign d           = d_q;
  assign s0          = slot_q[0];
  assign s1          = slot_q[1];
  assign frame_valid = fv_q;
  assign sync_err    = err_q;
  assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Directed bench for tdm_demux_4ch: a vector table for the per-sample behaviour
// plus a hand-written mid-frame reset sequence.
module tb_tdm_demux_4ch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic sync = 1'b0;
  logic a, b, c, d, s0, s1, frame_valid, locked, sync_err;

  int n_vec  = 0;
  int n_miss = 0;

  tdm_demux_4ch #(.WIDTH(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .s0          (s0),
    .s1          (s1),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  // expected bundle: {a,b,c,d, s1,s0, frame_valid, locked, sync_err}
  typedef struct packed {
    logic       v;
    logic       dd;
    logic       sy;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic dd, input logic sy,
                              input logic [3:0] abcd, input logic [1:0] s,
                              input logic fv, input logic lk, input logic er);
    vec_t r;
    r.v   = v;
    r.dd  = dd;
    r.sy  = sy;
    r.exp = {abcd, s, fv, lk, er};
    return r;
  endfunction

  task automatic chk(input string name, input logic [8:0] exp);
    logic [8:0] act;
    act = {a, b, c, d, s1, s0, frame_valid, locked, sync_err};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got abcd_s_fv_lk_err=%b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic dd, input logic sy);
    din_valid = v;
    din       = dd;
    sync      = sy;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input string name, input vec_t t);
    step(t.v, t.dd, t.sy);
    chk(name, t.exp);
  endtask

  initial begin
    // samples before any sync
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 0, 4'b0000, 2'd0, 0, 0, 0));
    // first frame 1,0,1,1
    tbl.push_back(mk(1, 1, 1, 4'b0000, 2'd0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 4'b0000, 2'd1, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 2'd2, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 4'b1011, 2'd3, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 4'b1011, 2'd3, 0, 1, 0));
    // early sync at slot 2 restarts the frame
    tbl.push_back(mk(1, 0, 1, 4'b1011, 2'd0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 4'b1011, 2'd1, 0, 1, 0));
    tbl.push_back(mk(1, 1, 1, 4'b1011, 2'd0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 4'b1011, 2'd1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 4'b1011, 2'd2, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 4'b1001, 2'd3, 1, 1, 0));
    // missing sync at slot 0 drops lock, frame held
    tbl.push_back(mk(1, 0, 0, 4'b1001, 2'd3, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 4'b1001, 2'd3, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 4'b1001, 2'd3, 0, 0, 0));
    // gapped frame 0,1,1,0 with gaps 0,1,3; sync during stalls ignored
    tbl.push_back(mk(1, 0, 1, 4'b1001, 2'd0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 4'b1001, 2'd1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 4'b1001, 2'd1, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 4'b1001, 2'd2, 0, 1, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 1, 4'b1001, 2'd2, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 4'b0110, 2'd3, 1, 1, 0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 1, 1, 4'b0110, 2'd3, 0, 1, 0));
    // back-to-back frames 1111 then 0000
    tbl.push_back(mk(1, 1, 1, 4'b0110, 2'd0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 4'b0110, 2'd1, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 4'b0110, 2'd2, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 4'b1111, 2'd3, 1, 1, 0));
    tbl.push_back(mk(1, 0, 1, 4'b1111, 2'd0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 4'b1111, 2'd1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 4'b1111, 2'd2, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 4'b0000, 2'd3, 1, 1, 0));

    #1;
    chk("reset_async", 9'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_state", 9'b0);

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // reset after slot 2 of a partial frame
    step(1, 1, 1);
    step(1, 1, 0);
    step(1, 1, 0);
    chk("pre_rst", {4'b0000, 2'd2, 1'b0, 1'b1, 1'b0});
    #2 rst = 1'b1;
    #1 chk("rst_mid_frame", 9'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) apply($sformatf("post_rst_nosync%0d", i), mk(1, 1, 0, 4'b0000, 2'd0, 0, 0, 0));
    apply("post_rst_s0", mk(1, 0, 1, 4'b0000, 2'd0, 0, 1, 0));
    apply("post_rst_s1", mk(1, 1, 0, 4'b0000, 2'd1, 0, 1, 0));
    apply("post_rst_s2", mk(1, 0, 0, 4'b0000, 2'd2, 0, 1, 0));
    apply("post_rst_s3", mk(1, 1, 0, 4'b0101, 2'd3, 1, 1, 0));
    apply("post_rst_idle", mk(0, 0, 0, 4'b0101, 2'd3, 0, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
